// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file with busy scoreboard.
// Optional feature macro used by the file set: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
package regfile_pkg;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

    localparam int REGFILE_MIN_AW = 1;

    // Address width for a register count; never below one bit so a 2-entry file still has an index.
    function automatic int regfile_aw(input int num_regs);
        return (num_regs > 2) ? $clog2(num_regs) : REGFILE_MIN_AW;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: same-cycle write bypass (port 1 over port 0 over storage) and busy lookup.
// Under REGFILE_ZERO_REG_EN the top gates writes/reservations to register 0 before they reach here.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int AW       = regfile_aw(NUM_REGS)
) (
    input  logic [AW-1:0]              raddr,
    input  logic                       we0,
    input  logic [AW-1:0]              waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [AW-1:0]              waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [NUM_REGS-1:0]        busy,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rbusy
);

    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] stored;

    always_comb begin
        hit0   = we0 && (waddr0 == raddr);
        hit1   = we1 && (waddr1 == raddr);
        stored = regs_flat[int'(raddr)*DATA_W +: DATA_W];

        if (hit1) begin
            rdata = wdata1;
        end else if (hit0) begin
            rdata = wdata0;
        end else begin
            rdata = stored;
        end

        // A load landing this cycle retires the reservation, so the consumer can proceed now.
        rbusy = busy[raddr] & ~hit1;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write register file with bypass, load-busy scoreboard and clear-all sweep.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (writes and reservations dropped).
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 8,
    parameter int  NUM_RD   = 2,
    localparam int AW       = regfile_aw(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [AW-1:0]            waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [AW-1:0]            waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        busy;
    clr_state_e                 state;
    logic [AW-1:0]              idx;

    logic we0_eff;
    logic we1_eff;
    logic rsv_eff;
    logic sweep_start;

`ifdef REGFILE_ZERO_REG_EN
    assign we0_eff = we0    && (waddr0   != '0);
    assign we1_eff = we1    && (waddr1   != '0);
    assign rsv_eff = rsv_en && (rsv_addr != '0);
`else
    assign we0_eff = we0;
    assign we1_eff = we1;
    assign rsv_eff = rsv_en;
`endif

    assign sweep_start = (state == CLR_IDLE) && clr_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLR_IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            busy     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state    <= CLR_SWEEP;
                        idx      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    regs[idx] <= '0;
                    // Terminal compare rather than relying on the AW-bit counter wrapping.
                    if (idx == LAST_IDX) begin
                        state    <= CLR_IDLE;
                        idx      <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: begin
                    state    <= CLR_IDLE;
                    idx      <= '0;
                    clr_busy <= 1'b0;
                end
            endcase

            // Functional writes come after the sweep clear so they win on the same register.
            if (we0_eff) begin
                regs[waddr0] <= wdata0;
            end
            if (we1_eff) begin
                regs[waddr1] <= wdata1;
            end

            if (sweep_start) begin
                busy <= '0;
            end else begin
                if (we1_eff) begin
                    busy[waddr1] <= 1'b0;
                end
                // Set after clear: a new load issued on the retiring register stays reserved.
                if (rsv_eff) begin
                    busy[rsv_addr] <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .AW       (AW)
        ) u_rd_port (
            .raddr     (raddr[k*AW +: AW]),
            .we0       (we0_eff),
            .waddr0    (waddr0),
            .wdata0    (wdata0),
            .we1       (we1_eff),
            .waddr1    (waddr1),
            .wdata1    (wdata1),
            .regs_flat (regs_flat),
            .busy      (busy),
            .rdata     (rdata[k*DATA_W +: DATA_W]),
            .rbusy     (rbusy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: vector table for read/write/bypass/scoreboard, hand sequences for the sweep.
// Expectations for register 0 follow REGFILE_ZERO_REG_EN.
module tb_regfile_mp_sb;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int NUM_RD   = 2;
    localparam int AW       = 3;
    localparam int NVEC     = 14;

    logic                     clk;
    logic                     rst;
    logic                     we0;
    logic [AW-1:0]            waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [AW-1:0]            waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic [NUM_RD*AW-1:0]     raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic                     clr_req;
    logic                     clr_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we0;
        logic [2:0]  wa0;
        logic [15:0] wd0;
        logic        we1;
        logic [2:0]  wa1;
        logic [15:0] wd1;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic        rsv;
        logic [2:0]  rsa;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        eb0;
        logic        eb1;
    } vec_t;

    vec_t tbl [NVEC];

    regfile_mp_sb #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we0      (we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic w0, input logic [2:0] a0, input logic [15:0] d0,
                                input logic w1, input logic [2:0] a1, input logic [15:0] d1,
                                input logic [2:0] r0, input logic [2:0] r1,
                                input logic rv, input logic [2:0] ra,
                                input logic [15:0] x0, input logic [15:0] x1,
                                input logic b0, input logic b1);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.ra0 = r0; v.ra1 = r1; v.rsv = rv; v.rsa = ra;
        v.e0 = x0;  v.e1 = x1;  v.eb0 = b0; v.eb1 = b1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
        raddr = '0;
    endtask

    task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
        raddr = {a1, a0};
    endtask

    // Move to the drive point of the next cycle (1 time unit after the edge).
    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    initial begin
        logic [15:0] z0_data;
        logic        z0_busy;
`ifdef REGFILE_ZERO_REG_EN
        z0_data = 16'h0000;
        z0_busy = 1'b0;
`else
        z0_data = 16'hFFFF;
        z0_busy = 1'b1;
`endif
        tbl[0]  = mk(0,0,16'h0,    0,0,16'h0,    3,0, 0,0, 16'h0000,16'h0000,0,0);
        tbl[1]  = mk(1,3,16'h1234, 0,0,16'h0,    3,4, 0,0, 16'h1234,16'h0000,0,0);
        tbl[2]  = mk(0,0,16'h0,    0,0,16'h0,    3,1, 0,0, 16'h1234,16'h0000,0,0);
        tbl[3]  = mk(1,5,16'hAAAA, 1,5,16'h5555, 3,5, 0,0, 16'h1234,16'h5555,0,0);
        tbl[4]  = mk(0,0,16'h0,    0,0,16'h0,    5,5, 0,0, 16'h5555,16'h5555,0,0);
        tbl[5]  = mk(0,0,16'h0,    0,0,16'h0,    2,2, 1,2, 16'h0000,16'h0000,0,0);
        tbl[6]  = mk(0,0,16'h0,    0,0,16'h0,    2,3, 0,0, 16'h0000,16'h1234,1,0);
        tbl[7]  = mk(0,0,16'h0,    1,2,16'hBEEF, 2,2, 0,0, 16'hBEEF,16'hBEEF,0,0);
        tbl[8]  = mk(0,0,16'h0,    0,0,16'h0,    2,5, 0,0, 16'hBEEF,16'h5555,0,0);
        tbl[9]  = mk(0,0,16'h0,    1,6,16'h1111, 6,6, 1,6, 16'h1111,16'h1111,0,0);
        tbl[10] = mk(0,0,16'h0,    0,0,16'h0,    6,7, 0,0, 16'h1111,16'h0000,1,0);
        tbl[11] = mk(1,1,16'h0101, 0,0,16'h0,    1,6, 0,0, 16'h0101,16'h1111,0,1);
        tbl[12] = mk(1,0,16'hFFFF, 0,0,16'h0,    0,0, 1,0, z0_data,z0_data,0,0);
        tbl[13] = mk(0,0,16'h0,    0,0,16'h0,    0,1, 0,0, z0_data,16'h0101,z0_busy,0);

        idle_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("reset_clr_busy", {31'd0, clr_busy}, 32'd0);
        check("reset_rdata", {rdata}, 32'd0);
        check("reset_rbusy", {30'd0, rbusy}, 32'd0);

        for (int v = 0; v < NVEC; v++) begin
            next_cyc();
            we0 = tbl[v].we0; waddr0 = tbl[v].wa0; wdata0 = tbl[v].wd0;
            we1 = tbl[v].we1; waddr1 = tbl[v].wa1; wdata1 = tbl[v].wd1;
            rd(tbl[v].ra0, tbl[v].ra1);
            rsv_en = tbl[v].rsv; rsv_addr = tbl[v].rsa;
            #4;
            check($sformatf("v%0d_rdata0", v), {16'd0, rdata[15:0]},  {16'd0, tbl[v].e0});
            check($sformatf("v%0d_rdata1", v), {16'd0, rdata[31:16]}, {16'd0, tbl[v].e1});
            check($sformatf("v%0d_rbusy0", v), {31'd0, rbusy[0]}, {31'd0, tbl[v].eb0});
            check($sformatf("v%0d_rbusy1", v), {31'd0, rbusy[1]}, {31'd0, tbl[v].eb1});
        end

        // Sweep: entry clears busy (beats a same-edge reservation), re-request ignored, late write wins.
        next_cyc();
        clr_req = 1'b1; rsv_en = 1'b1; rsv_addr = 3'd3;
        #4;
        check("sweep_pre_clr_busy", {31'd0, clr_busy}, 32'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            next_cyc();
            if (i == 0) rd(3'd6, 3'd3);
            if (i == 2) begin rsv_en = 1'b1; rsv_addr = 3'd4; end
            if (i == 3) clr_req = 1'b1;
            if (i == 5) rd(3'd1, 3'd5);
            if (i == 7) begin we0 = 1'b1; waddr0 = 3'd7; wdata0 = 16'h00FF; rd(3'd7, 3'd2); end
            #4;
            check($sformatf("sweep_c%0d_clr_busy", i), {31'd0, clr_busy}, 32'd1);
            if (i == 0) check("sweep_entry_rbusy", {30'd0, rbusy}, 32'd0);
            if (i == 5) check("sweep_mid_rdata", rdata, {16'h5555, 16'h0000});
            if (i == 7) check("sweep_last_bypass", rdata, {16'h0000, 16'h00FF});
        end
        for (int p = 0; p < NUM_REGS / 2; p++) begin
            next_cyc();
            rd(3'(2*p), 3'(2*p+1));
            #4;
            check($sformatf("post_sweep_clr_busy_%0d", p), {31'd0, clr_busy}, 32'd0);
            check($sformatf("post_sweep_rdata_%0d", p), rdata,
                  (p == 3) ? {16'h00FF, 16'h0000} : 32'd0);
            check($sformatf("post_sweep_rbusy_%0d", p), {30'd0, rbusy},
                  (p == 2) ? 32'd1 : 32'd0);
        end

        // Reset during a sweep abandons it and returns everything to the reset state.
        next_cyc();
        we0 = 1'b1; waddr0 = 3'd6; wdata0 = 16'h6666;
        next_cyc();
        clr_req = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            next_cyc();
            if (i == 1) begin rsv_en = 1'b1; rsv_addr = 3'd5; end
            if (i == 3) begin
                rd(3'd5, 3'd6);
                #1;
                check("rst_pre_rbusy5", {31'd0, rbusy[0]}, 32'd1);
                check("rst_pre_rdata6", {16'd0, rdata[31:16]}, 32'h6666);
            end
        end
        rst = 1'b1;
        rd(3'd5, 3'd6);
        #1;
        check("rst_mid_clr_busy", {31'd0, clr_busy}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_rbusy", {30'd0, rbusy}, 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            rd(3'd7, 3'd6);
            #4;
            check($sformatf("rst_after_%0d_clr_busy", i), {31'd0, clr_busy}, 32'd0);
            check($sformatf("rst_after_%0d_rdata", i), rdata, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
